hazard_fwd_ctrl: RTL
====================

# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 4-stage D→EX→MEM→WB integer pipeline. It tracks the destination register, write enable and load flag of every in-flight instruction. From these it drives the decode-stage bypass selects and the writeback write port of the register file. It also generates the load-use stall, the branch-flush bubble and a saturating stall-cycle counter.

## Interface
Parameters:
- ADDR_SIZE, 5: register index width.
- REG_NUM, 32: register count; index 0 is hardwired zero.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- D_valid  in  1  decode slot holds a real instruction.
- D_ra, D_rb  in  ADDR_SIZE each  source register indices of the decode instruction.
- D_uses_ra, D_uses_rb  in  1 each  the instruction actually reads that operand.
- D_rd  in  ADDR_SIZE  destination index of the decode instruction.
- D_we  in  1  the decode instruction writes D_rd.
- D_ld  in  1  the decode instruction is a load.
- flush  in  1  branch taken in EX; squash the decode instruction.
- MEM_busy  in  1  data memory not ready; freeze EX and MEM.
- EX_D_bp, MEM_D_bp, WB_D_bp  out  2 each  bypass selects, encoded {ra, rb}.
- stall_D  out  1  hold fetch/decode; a bubble enters EX.
- WB_we  out  1  register-file write enable.
- WB_rd  out  ADDR_SIZE  register-file write index.
- stall_cnt  out  CNT_W  count of stall cycles caused by load-use.

## Operation
Each of EX, MEM and WB holds a record {v, rd, we, ld}. Reset clears every record to zero.

Load-use hazard, `lu`:
- Condition: D_valid & ex.v & ex.we & ex.ld & ex.rd≠0.
- And at least one used source matches ex.rd, i.e. (D_uses_ra & D_ra==ex.rd) | (D_uses_rb & D_rb==ex.rd).

Stall and update rules:
- stall_D = (lu & ~flush) | MEM_busy.
- Normal cycle, MEM_busy=0:
  - EX ← bubble if flush or lu; otherwise EX ← {D_valid, D_rd, D_we, D_ld}.
  - MEM ← EX; WB ← MEM.
- MEM_busy=1:
  - EX and MEM hold their contents.
  - WB ← bubble (v=0).
  - flush arriving during MEM_busy is ignored by this block. The front end holds flush asserted until the freeze ends.

Bypass selects, evaluated per operand `op` ∈ {ra, rb} with operand index `s` (D_ra or D_rb):
- A stage X matches when D_uses_op & s≠0 & X.v & X.we & X.rd==s.
- Per operand, exactly the highest-priority matching stage is asserted, in order EX > MEM > WB. Selects are one-hot or zero.
- An EX match whose EX record is a load never asserts EX_D_bp; that case is covered by `lu`.
- All selects are 0 when stall_D=1 or D_valid=0.

Writeback port:
- WB_we = wb.v & wb.we & (wb.rd≠0).
- WB_rd = wb.rd.

Stall counter:
- stall_cnt increments by 1 on every rising edge where lu & ~flush & ~MEM_busy.
- It saturates at all-ones and never wraps. Reset clears it to 0.

## Timing
- Reset values: all stage records 0; WB_we=0, WB_rd=0, stall_cnt=0; all bypass selects 0; stall_D follows MEM_busy.
- Bypass selects and stall_D are combinational from the stage records and the D/flush/MEM_busy inputs. They are valid in the same cycle as D_* and have no registered latency.
- WB_we and WB_rd come directly from the WB record, so they are registered.
- An instruction's destination appears as ex.rd 1 cycle after it leaves D, as mem.rd after 2 cycles, and as wb.rd (and on WB_we) after 3 cycles with no freeze.
- A load-use pair costs exactly 1 stall cycle. The next cycle, the load sits in MEM and MEM_D_bp forwards it.
- Asserting rst_n low mid-freeze or mid-stall clears state immediately and asynchronously. The first edge after deassertion behaves as a normal cycle.

## Test plan
- ALU back-to-back: `add x5` then D_ra=5, D_uses_ra=1 on the next cycle → EX_D_bp=2'b10, MEM_D_bp=WB_D_bp=0, stall_D=0.
- Priority: x7 written by instructions in MEM and WB, D_rb=7 → MEM_D_bp=2'b01, WB_D_bp=0. Next cycle, with no new x7 writer → WB_D_bp=2'b01.
- Load-use: `ld x3` in EX, D_ra=3 → stall_D=1, all selects 0, EX receives a bubble, stall_cnt 0→1. Next cycle → MEM_D_bp=2'b10, stall_D=0.
- x0 and unused operands: writer of rd=0 in EX with D_ra=0; writer in EX matching D_rb with D_uses_rb=0 → all selects 0. Also WB_we=0 when wb.rd=0 reaches WB.
- Freeze: MEM_busy=1 for 3 cycles with loads in EX and MEM → EX/MEM records unchanged, WB_we=0 for 3 cycles, stall_cnt unchanged. The MEM record retires to WB 1 cycle after release.
- Flush with lu: flush=1 and lu=1 together → stall_D=0, EX bubble, stall_cnt unchanged. Counter preloaded to 16'hFFFF plus one more lu cycle → stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding control for a 4-stage D->EX->MEM->WB integer pipeline.
// Tracks in-flight destination records and drives bypass selects, load-use stall and WB port.
module hazard_fwd_ctrl #(
    parameter int ADDR_SIZE = 5,
    parameter int REG_NUM   = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic                 D_uses_ra,
    input  logic                 D_uses_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_we,
    input  logic                 D_ld,
    input  logic                 flush,
    input  logic                 MEM_busy,
    output logic [1:0]           EX_D_bp,
    output logic [1:0]           MEM_D_bp,
    output logic [1:0]           WB_D_bp,
    output logic                 stall_D,
    output logic                 WB_we,
    output logic [ADDR_SIZE-1:0] WB_rd,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef struct packed {
        logic                 v;
        logic [ADDR_SIZE-1:0] rd;
        logic                 we;
        logic                 ld;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    if (REG_NUM > (2 ** ADDR_SIZE)) begin : g_bad_cfg
        $error("REG_NUM does not fit in ADDR_SIZE index bits");
    end

    stage_t ex_q, ex_d;
    stage_t mem_q, mem_d;
    stage_t wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       lu;
    logic       fwd_en;
    logic [1:0] ex_m, mem_m, wb_m;

    function automatic logic stage_match(input logic use_op,
                                         input logic [ADDR_SIZE-1:0] src,
                                         input stage_t st);
        return use_op && (src != '0) && st.v && st.we && (st.rd == src);
    endfunction

    // Operand bit ordering throughout: [1] = ra, [0] = rb.
    always_comb begin
        ex_m  = '0;
        mem_m = '0;
        wb_m  = '0;
        ex_m[1]  = stage_match(D_uses_ra, D_ra, ex_q);
        ex_m[0]  = stage_match(D_uses_rb, D_rb, ex_q);
        mem_m[1] = stage_match(D_uses_ra, D_ra, mem_q);
        mem_m[0] = stage_match(D_uses_rb, D_rb, mem_q);
        wb_m[1]  = stage_match(D_uses_ra, D_ra, wb_q);
        wb_m[0]  = stage_match(D_uses_rb, D_rb, wb_q);

        lu = D_valid && ex_q.v && ex_q.we && ex_q.ld && (ex_q.rd != '0) &&
             ((D_uses_ra && (D_ra == ex_q.rd)) || (D_uses_rb && (D_rb == ex_q.rd)));

        stall_D = (lu && !flush) || MEM_busy;
        fwd_en  = D_valid && !stall_D;
    end

    // A matching load in EX still claims top priority so an older MEM/WB value
    // of the same register can never be forwarded in its place.
    always_comb begin
        EX_D_bp  = '0;
        MEM_D_bp = '0;
        WB_D_bp  = '0;
        if (fwd_en) begin
            EX_D_bp  = ex_m & {2{!ex_q.ld}};
            MEM_D_bp = ~ex_m & mem_m;
            WB_D_bp  = ~ex_m & ~mem_m & wb_m;
        end
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = BUBBLE;
        cnt_d = cnt_q;
        if (!MEM_busy) begin
            if (flush || lu) begin
                ex_d = BUBBLE;
            end else begin
                ex_d.v  = D_valid;
                ex_d.rd = D_rd;
                ex_d.we = D_we;
                ex_d.ld = D_ld;
            end
            mem_d = ex_q;
            wb_d  = mem_q;
            if (lu && !flush && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign WB_we     = wb_q.v && wb_q.we && (wb_q.rd != '0);
    assign WB_rd     = wb_q.rd;
    assign stall_cnt = cnt_q;

endmodule
